// File: rtl/riscv_pkg.sv
// Shared RISC-V load/store definitions: funct3 encodings, LSU FSM states,
// the latched request record and the request legality check.
package riscv_pkg;

    typedef enum logic [2:0] {
        F3_B  = 3'b000,
        F3_H  = 3'b001,
        F3_W  = 3'b010,
        F3_BU = 3'b100,
        F3_HU = 3'b101
    } funct3_e;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        WRITE = 2'd2,
        RESP  = 2'd3
    } lsu_state_e;

    typedef struct packed {
        logic        we;
        logic [2:0]  funct3;
        logic [31:0] addr;
        logic [31:0] wdata;
    } lsu_req_t;

    // Illegal encoding for the direction, or address not aligned to the access size.
    function automatic logic lsu_req_err(input logic we, input logic [2:0] f3, input logic [1:0] off);
        logic legal;
        logic mis;
        if (we) legal = (f3 == F3_B) || (f3 == F3_H) || (f3 == F3_W);
        else    legal = (f3 == F3_B) || (f3 == F3_H) || (f3 == F3_W) ||
                        (f3 == F3_BU) || (f3 == F3_HU);
        case (f3[1:0])
            2'b01:   mis = off[0];
            2'b10:   mis = |off;
            default: mis = 1'b0;
        endcase
        return !legal || mis;
    endfunction

endpackage

// File: rtl/load_store_unit_if.sv
// Request/response handshake plus data-memory port of the load/store unit.
interface load_store_unit_if;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [2:0]  funct3;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        resp_valid;
    logic [31:0] rdata;
    logic        resp_err;
    logic [31:0] mem_addr;
    logic        mem_we;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;

    modport slave (
        input  req_valid, req_we, funct3, addr, wdata, mem_rdata,
        output req_ready, resp_valid, rdata, resp_err, mem_addr, mem_we, mem_wdata
    );

    modport master (
        output req_valid, req_we, funct3, addr, wdata, mem_rdata,
        input  req_ready, resp_valid, rdata, resp_err, mem_addr, mem_we, mem_wdata
    );
endinterface

// File: rtl/lsu_align.sv
// Byte/halfword lane handling: load extraction with sign/zero extension and
// read-modify-write merge of sub-word store data into the old memory word.
module lsu_align
    import riscv_pkg::*;
(
    input  logic [2:0]  funct3,
    input  logic [1:0]  byte_off,
    input  logic [31:0] ld_word,
    input  logic [31:0] old_word,
    input  logic [31:0] st_data,
    output logic [31:0] ld_data,
    output logic [31:0] st_word
);
    logic [7:0]  ld_byte;
    logic [15:0] ld_half;

    // Select the addressed lane and extend it according to the load type.
    always_comb begin
        ld_byte = ld_word[{byte_off, 3'b000} +: 8];
        ld_half = ld_word[{byte_off[1], 4'b0000} +: 16];
        case (funct3)
            F3_B:    ld_data = {{24{ld_byte[7]}}, ld_byte};
            F3_H:    ld_data = {{16{ld_half[15]}}, ld_half};
            F3_W:    ld_data = ld_word;
            F3_BU:   ld_data = {24'h0, ld_byte};
            F3_HU:   ld_data = {16'h0, ld_half};
            default: ld_data = 32'h0;
        endcase
    end

    // Replace only the addressed lane; a word store overwrites everything.
    always_comb begin
        st_word = old_word;
        case (funct3)
            F3_B:    st_word[{byte_off, 3'b000} +: 8]     = st_data[7:0];
            F3_H:    st_word[{byte_off[1], 4'b0000} +: 16] = st_data[15:0];
            F3_W:    st_word = st_data;
            default: st_word = old_word;
        endcase
    end
endmodule

// File: rtl/load_store_unit.sv
// Single-outstanding load/store unit. Sub-word stores do a read-modify-write
// of the target word; errored requests respond without touching memory.
module load_store_unit
    import riscv_pkg::*;
(
    input logic               clk,
    input logic               rst_n,
    load_store_unit_if.slave  bus
);
    lsu_state_e  state;
    lsu_req_t    req_q;
    logic [31:0] old_q;
    logic        resp_valid_q;
    logic        resp_err_q;
    logic [31:0] rdata_q;
    logic [31:0] ld_data;
    logic [31:0] st_word;

    lsu_align u_align (
        .funct3   (req_q.funct3),
        .byte_off (req_q.addr[1:0]),
        .ld_word  (bus.mem_rdata),
        .old_word (old_q),
        .st_data  (req_q.wdata),
        .ld_data  (ld_data),
        .st_word  (st_word)
    );

    assign bus.req_ready  = (state == IDLE);
    // Write strobe decoded from the state register alone so reset kills it at once.
    assign bus.mem_we     = (state == WRITE);
    assign bus.mem_addr   = {req_q.addr[31:2], 2'b00};
    assign bus.mem_wdata  = st_word;
    assign bus.resp_valid = resp_valid_q;
    assign bus.resp_err   = resp_err_q;
    assign bus.rdata      = rdata_q;

    // Request FSM; response outputs are registered on entry to RESP and cleared otherwise.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= IDLE;
            req_q        <= '0;
            old_q        <= '0;
            resp_valid_q <= 1'b0;
            resp_err_q   <= 1'b0;
            rdata_q      <= '0;
        end else begin
            resp_valid_q <= 1'b0;
            resp_err_q   <= 1'b0;
            rdata_q      <= '0;
            case (state)
                IDLE: begin
                    if (bus.req_valid) begin
                        req_q <= '{we: bus.req_we, funct3: bus.funct3,
                                   addr: bus.addr, wdata: bus.wdata};
                        if (lsu_req_err(bus.req_we, bus.funct3, bus.addr[1:0])) begin
                            state        <= RESP;
                            resp_valid_q <= 1'b1;
                            resp_err_q   <= 1'b1;
                        end else if (bus.req_we && (bus.funct3 == F3_W)) begin
                            state <= WRITE;
                        end else begin
                            state <= READ;
                        end
                    end
                end
                READ: begin
                    old_q <= bus.mem_rdata;
                    if (req_q.we) begin
                        state <= WRITE;
                    end else begin
                        state        <= RESP;
                        resp_valid_q <= 1'b1;
                        rdata_q      <= ld_data;
                    end
                end
                WRITE: begin
                    state        <= RESP;
                    resp_valid_q <= 1'b1;
                end
                RESP:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_load_store_unit.sv
// Load/store unit bench: directed corner cases plus random traffic against a
// byte-addressed reference memory.
module tb_load_store_unit;
    logic clk = 1'b0;
    logic rst_n = 1'b0;

    load_store_unit_if bus();

    load_store_unit dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    // Word memory seen by the DUT; single writer process handles DUT writes and preloads.
    logic [31:0] mem_words [64];
    logic        pre_en = 1'b0;
    logic [5:0]  pre_idx = '0;
    logic [31:0] pre_val = '0;

    always @(posedge clk) begin
        if (bus.mem_we) mem_words[bus.mem_addr[7:2]] <= bus.mem_wdata;
        if (pre_en)     mem_words[pre_idx] <= pre_val;
    end

    assign bus.mem_rdata = mem_words[bus.mem_addr[7:2]];

    // Reference memory as bytes, little-endian.
    logic [7:0] bmem [256];

    int n_chk = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] ref_word(input int idx);
        return {bmem[4*idx+3], bmem[4*idx+2], bmem[4*idx+1], bmem[4*idx]};
    endfunction

    function automatic int acc_size(input logic [2:0] f3);
        return 1 << f3[1:0];
    endfunction

    function automatic bit ref_err(input logic we, input logic [2:0] f3, input logic [31:0] a);
        bit legal;
        if (we) legal = (f3 <= 3'd2);
        else    legal = (f3 <= 3'd2) || (f3 == 3'd4) || (f3 == 3'd5);
        if (!legal) return 1'b1;
        return (a % acc_size(f3)) != 0;
    endfunction

    function automatic logic [31:0] ref_load(input logic [2:0] f3, input logic [31:0] a);
        int     size;
        longint v;
        size = acc_size(f3);
        v = 0;
        for (int i = size - 1; i >= 0; i--) v = v * 256 + longint'(bmem[int'(a) + i]);
        if (!f3[2] && size < 4 && v >= (longint'(1) << (8 * size - 1)))
            v = v - (longint'(1) << (8 * size));
        return v[31:0];
    endfunction

    task automatic set_word(input int idx, input logic [31:0] w);
        pre_en  = 1'b1;
        pre_idx = 6'(idx);
        pre_val = w;
        for (int i = 0; i < 4; i++) bmem[4*idx+i] = w[8*i +: 8];
        @(posedge clk);
        #1 pre_en = 1'b0;
        @(negedge clk);
    endtask

    // Observations of the last transaction.
    int          o_wait, o_lat, o_wen, o_wek;
    logic [31:0] o_rd, o_wd, o_wa;
    logic        o_err;

    // Drive one request (called at a negedge), record its response, and check
    // it against the reference model. Ends at the negedge in the response cycle.
    task automatic txn(input logic we, input logic [2:0] f3, input logic [31:0] a,
                       input logic [31:0] wd, input bit hold);
        bit          e_err;
        int          e_lat;
        logic [31:0] e_rd;
        bus.req_valid = 1'b1;
        bus.req_we    = we;
        bus.funct3    = f3;
        bus.addr      = a;
        bus.wdata     = wd;
        o_wait = 0;
        while (!bus.req_ready && o_wait < 20) begin
            @(negedge clk);
            o_wait++;
        end
        chk("accept", 32'(bus.req_ready), 32'd1);
        @(posedge clk);
        o_lat = 0; o_wen = 0; o_wek = 0; o_rd = '0; o_wd = '0; o_wa = '0; o_err = 1'b0;
        for (int k = 1; k <= 8; k++) begin
            @(negedge clk);
            if (!hold) bus.req_valid = 1'b0;
            if (bus.mem_we) begin
                o_wen++;
                if (o_wek == 0) begin
                    o_wek = k;
                    o_wd  = bus.mem_wdata;
                    o_wa  = bus.mem_addr;
                end
            end
            if (bus.resp_valid) begin
                o_lat = k;
                o_rd  = bus.rdata;
                o_err = bus.resp_err;
                break;
            end
        end
        e_err = ref_err(we, f3, a);
        if (e_err)                  e_lat = 1;
        else if (we && f3 == 3'd2)  e_lat = 2;
        else if (we)                e_lat = 3;
        else                        e_lat = 2;
        e_rd = (!we && !e_err) ? ref_load(f3, a) : 32'h0;
        chk("latency", 32'(o_lat), 32'(e_lat));
        chk("resp_err", 32'(o_err), 32'(e_err));
        chk("rdata", o_rd, e_rd);
        chk("write_count", 32'(o_wen), (we && !e_err) ? 32'd1 : 32'd0);
        if (we && !e_err) begin
            chk("write_cycle", 32'(o_wek), (f3 == 3'd2) ? 32'd1 : 32'd2);
            chk("write_addr", o_wa, a & 32'hFFFF_FFFC);
            for (int i = 0; i < acc_size(f3); i++) bmem[int'(a) + i] = wd[8*i +: 8];
            chk("write_data", o_wd, ref_word(int'(a[7:2])));
        end
    endtask

    int resp_seen;

    initial begin
        bus.req_valid = 1'b0;
        bus.req_we    = 1'b0;
        bus.funct3    = 3'd0;
        bus.addr      = '0;
        bus.wdata     = '0;

        // Reset values.
        #2;
        chk("rst_ready", 32'(bus.req_ready), 32'd1);
        chk("rst_resp_valid", 32'(bus.resp_valid), 32'd0);
        chk("rst_resp_err", 32'(bus.resp_err), 32'd0);
        chk("rst_rdata", bus.rdata, 32'h0);
        chk("rst_mem_we", 32'(bus.mem_we), 32'd0);
        chk("rst_mem_wdata", bus.mem_wdata, 32'h0);

        @(negedge clk);
        for (int i = 0; i < 64; i++) set_word(i, $urandom);
        rst_n = 1'b1;
        @(negedge clk);

        // SW 0x10.
        txn(1'b1, 3'd2, 32'h10, 32'hDEADBEEF, 1'b0);
        chk("sw_we_cycle", 32'(o_wek), 32'd1);
        chk("sw_mem_addr", o_wa, 32'h10);
        chk("sw_mem_wdata", o_wd, 32'hDEADBEEF);
        chk("sw_lat", 32'(o_lat), 32'd2);
        chk("sw_err", 32'(o_err), 32'd0);
        @(negedge clk);
        chk("resp_pulse", 32'(bus.resp_valid), 32'd0);
        chk("ready_after_resp", 32'(bus.req_ready), 32'd1);

        // SB merge into an existing word.
        set_word(4, 32'h11223344);
        txn(1'b1, 3'd0, 32'h11, 32'h000000AA, 1'b0);
        chk("sb_mem_wdata", o_wd, 32'h1122AA44);
        chk("sb_we_cycle", 32'(o_wek), 32'd2);
        chk("sb_lat", 32'(o_lat), 32'd3);

        // Sign/zero extended sub-word loads.
        set_word(4, 32'h80FF0000);
        txn(1'b0, 3'd0, 32'h13, 32'h0, 1'b0);
        chk("lb_rdata", o_rd, 32'hFFFFFF80);
        txn(1'b0, 3'd4, 32'h13, 32'h0, 1'b0);
        chk("lbu_rdata", o_rd, 32'h00000080);
        txn(1'b0, 3'd5, 32'h12, 32'h0, 1'b0);
        chk("lhu_rdata", o_rd, 32'h000080FF);

        // Misaligned requests.
        txn(1'b0, 3'd2, 32'h06, 32'h0, 1'b0);
        chk("lw_mis_err", 32'(o_err), 32'd1);
        chk("lw_mis_lat", 32'(o_lat), 32'd1);
        chk("lw_mis_rdata", o_rd, 32'h0);
        txn(1'b1, 3'd1, 32'h03, 32'h1234, 1'b0);
        chk("sh_mis_err", 32'(o_err), 32'd1);
        chk("sh_mis_no_we", 32'(o_wen), 32'd0);

        // Reset asserted during the WRITE cycle of an SH.
        @(negedge clk);
        bus.req_valid = 1'b1;
        bus.req_we    = 1'b1;
        bus.funct3    = 3'd1;
        bus.addr      = 32'h42;
        bus.wdata     = 32'h5555;
        chk("rstw_ready", 32'(bus.req_ready), 32'd1);
        @(posedge clk);
        @(negedge clk);
        bus.req_valid = 1'b0;
        @(negedge clk);
        chk("rstw_we_before", 32'(bus.mem_we), 32'd1);
        rst_n = 1'b0;
        #1;
        chk("rstw_we_drop", 32'(bus.mem_we), 32'd0);
        resp_seen = 0;
        @(negedge clk);
        rst_n = 1'b1;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            if (bus.resp_valid) resp_seen++;
        end
        chk("rstw_no_resp", 32'(resp_seen), 32'd0);
        chk("rstw_ready_after", 32'(bus.req_ready), 32'd1);
        chk("rstw_mem_untouched", mem_words[16], ref_word(16));

        // Back-to-back SW then LW with req_valid held.
        txn(1'b1, 3'd2, 32'h20, 32'hCAFE0123, 1'b1);
        txn(1'b0, 3'd2, 32'h20, 32'h0, 1'b0);
        chk("b2b_wait", 32'(o_wait), 32'd1);
        chk("b2b_rdata", o_rd, 32'hCAFE0123);

        // Random traffic.
        for (int n = 0; n < 300; n++) begin
            txn(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)),
                32'($urandom_range(0, 255)), $urandom, 1'($urandom_range(0, 1)));
        end
        @(negedge clk);
        bus.req_valid = 1'b0;
        repeat (3) @(negedge clk);

        for (int i = 0; i < 64; i++) chk("final_mem", mem_words[i], ref_word(i));

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end
endmodule

// File: doc/load_store_unit.md
LOAD_STORE_UNIT -- requirements
Module: load_store_unit

Interface
REQ-001 SHALL have port clk, input, 1: sole clock, rising edge.
REQ-002 SHALL have port rst_n, input, 1: asynchronous, active-low reset.
REQ-003 SHALL have port req_valid, input, 1: memory request present.
REQ-004 SHALL have port req_ready, output, 1: request accepted when req_valid && req_ready at a rising edge.
REQ-005 SHALL have port req_we, input, 1: 1 = store, 0 = load.
REQ-006 SHALL have port funct3, input, 3: LB=000, LH=001, LW=010, LBU=100, LHU=101; SB=000, SH=001, SW=010.
REQ-007 SHALL have port addr, input, 32: byte address.
REQ-008 SHALL have port wdata, input, 32: store data, LSBs used for SB/SH.
REQ-009 SHALL have port resp_valid, output, 1: one-cycle completion pulse.
REQ-010 SHALL have port rdata, output, 32: extended load result, valid with resp_valid.
REQ-011 SHALL have port resp_err, output, 1: misaligned or illegal request, valid with resp_valid.
REQ-012 SHALL have port mem_addr, output, 32: word address to data memory, {addr_q[31:2],2'b00}.
REQ-013 SHALL have port mem_we, output, 1: word write strobe to data memory.
REQ-014 SHALL have port mem_wdata, output, 32: full word written to data memory.
REQ-015 SHALL have port mem_rdata, input, 32: asynchronous read word from data memory.

Function
REQ-016 SHALL implement FSM states IDLE, READ, WRITE, RESP; req_ready = (state==IDLE).
REQ-017 SHALL latch req_we, funct3, addr, wdata on acceptance; inputs are ignored outside acceptance.
REQ-018 SHALL flag an error when LH/LHU/SH has addr[0]=1, LW/SW has addr[1:0]!=0, or funct3 is not a listed encoding for the direction.
REQ-019 SHALL transition from IDLE on acceptance: error -> RESP; SW -> WRITE; all loads, SB, SH -> READ.
REQ-020 SHALL capture mem_rdata into old_q in READ, then go to RESP for loads and WRITE for SB/SH.
REQ-021 SHALL assert mem_we only in WRITE; mem_wdata = wdata_q for SW, else old_q with the addressed byte/halfword lane replaced by wdata_q[7:0]/[15:0]; WRITE -> RESP.
REQ-022 SHALL in RESP pulse resp_valid for exactly one cycle, then return to IDLE.
REQ-023 SHALL set rdata to the addressed lane of old_q: sign-extended for LB/LH, zero-extended for LBU/LHU, whole word for LW; rdata=0 for stores and errors.
REQ-024 SHALL give latency from acceptance edge N to resp_valid: error N+1, SW N+2, loads N+2, SB/SH N+3.
REQ-025 SHALL never assert mem_we for an errored request.
REQ-026 SHALL accept a new request in the IDLE cycle directly following RESP (back-to-back, one-cycle bubble).
REQ-027 SHALL compute mem_we combinationally from state only, so no glitch or spurious write occurs outside WRITE.

Reset
REQ-028 SHALL on rst_n low asynchronously force state=IDLE, req_ready=1, resp_valid=0, resp_err=0, rdata=0, mem_we=0, mem_wdata=0, and all latched registers to 0.
REQ-029 SHALL abort an in-flight request when reset is asserted mid-operation (including in WRITE) with no write and no response; mem_we falls in the same cycle.

Structure
REQ-030 SHALL take funct3 encodings and the FSM state enum from shared package riscv_pkg.
REQ-031 SHALL place lane extraction, sign extension and store merge in combinational sub-module lsu_align; the FSM and registers remain in load_store_unit.

Verification
REQ-032 SHALL verify SW addr=0x10, wdata=0xDEADBEEF -> mem_we in cycle N+1 at mem_addr 0x10, resp_valid at N+2, err=0.
REQ-033 SHALL verify SB addr=0x11, wdata=0xAA over old word 0x11223344 -> mem_wdata=0x1122AA44 at N+2, resp at N+3.
REQ-034 SHALL verify LB addr=0x13 on word 0x80FF0000 -> rdata=0xFFFFFF80; LBU at the same address -> 0x00000080; LHU addr=0x12 -> 0x000080FF.
REQ-035 SHALL verify LW addr=0x06 -> resp_err=1 at N+1, rdata=0; SH addr=0x03 -> resp_err=1, mem_we never asserted.
REQ-036 SHALL verify rst_n pulsed low during WRITE of an SH -> mem_we drops immediately, no resp_valid, req_ready=1 after release.
REQ-037 SHALL verify back-to-back SW then LW to 0x20 with req_valid held -> second request accepted in the cycle after the first RESP, rdata equals the stored word.
